sig_job_scheduler: RTL

//  Sequences the signing datapath: Keccak256 hash, then ECDSA sign, or ECDSA verify alone.

---
 rtl/sig_sched_pkg.sv | 29 ++
 rtl/sched_rr_arbiter.sv | 28 ++
 rtl/sig_job_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sig_sched_pkg.sv
// Shared types and constants for the signing job scheduler.
package sig_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        IDLE,
        H_START,
        H_WAIT,
        S_START,
        S_WAIT,
        V_START,
        V_WAIT,
        RESP
    } state_e;

    // Requester op codes (1x is invalid)
    localparam logic [1:0] OP_SIGN = 2'b00;
    localparam logic [1:0] OP_VRFY = 2'b01;

    // Response status codes
    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_VFAIL = 2'b01;
    localparam logic [1:0] ST_ERR   = 2'b10;
    localparam logic [1:0] ST_TMO   = 2'b11;

    // Default engine wait limit when the timeout feature is built in
    localparam int TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/sched_rr_arbiter.sv
// Two-way round-robin arbiter. The pointer remembers the last granted
// requester and only moves when the grant is actually consumed.
module sched_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q;

    // A lone requester always wins; a tie goes to the one not granted last
    always_comb begin
        grant = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
    end

    // Pointer resets to "1 granted last" so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/sig_job_scheduler.sv
// Signing job scheduler: arbitrates two requesters and sequences the
// Keccak256 hash + ECDSA sign engines, or the ECDSA verifier alone, then
// returns one tagged status response per accepted job.
// Optional feature macro: SIG_SCHED_TIMEOUT_EN (engine wait-state timeout).
module sig_job_scheduler
    import sig_sched_pkg::*;
#(
    parameter int TAG_W = 4
`ifdef SIG_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [3:0]         req_op,
    input  logic [2*TAG_W-1:0] req_tag,
    output logic               hash_start,
    input  logic               hash_done,
    output logic               sign_start,
    input  logic               sign_done,
    input  logic               sign_error,
    output logic               vrfy_start,
    input  logic               vrfy_done,
    input  logic               vrfy_error,
    input  logic               vrfy_valid,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [1:0]         rsp_status,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [1:0]         grant;
    logic               accept;
    logic               gnt_idx;
    logic [1:0]         gnt_op;
    logic [TAG_W-1:0]   gnt_tag;
    logic               id_q;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         status_q, status_d;
    logic               tmo_hit;

    sched_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Jobs are only taken in IDLE, which keeps at most one job in flight
    assign req_ready = (state_q == IDLE) ? (req_valid & grant) : 2'b00;
    assign accept    = |req_ready;
    assign gnt_idx   = grant[1];
    assign gnt_op    = gnt_idx ? req_op[3:2] : req_op[1:0];
    assign gnt_tag   = gnt_idx ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

`ifdef SIG_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] tmo_cnt_q;

    // Counter is zeroed in each START state so it reads 0 on WAIT entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == H_START || state_q == S_START || state_q == V_START) begin
            tmo_cnt_q <= '0;
        end else if (state_q == H_WAIT || state_q == S_WAIT || state_q == V_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state and response status; a done in the same cycle beats timeout
    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (gnt_op)
                        OP_SIGN: state_d = H_START;
                        OP_VRFY: state_d = V_START;
                        default: begin
                            state_d  = RESP;
                            status_d = ST_ERR;
                        end
                    endcase
                end
            end
            H_START: state_d = H_WAIT;
            H_WAIT: begin
                if (hash_done) begin
                    state_d = S_START;
                end else if (tmo_hit) begin
                    state_d  = RESP;
                    status_d = ST_TMO;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (sign_done) begin
                    state_d  = RESP;
                    status_d = sign_error ? ST_ERR : ST_OK;
                end else if (tmo_hit) begin
                    state_d  = RESP;
                    status_d = ST_TMO;
                end
            end
            V_START: state_d = V_WAIT;
            V_WAIT: begin
                if (vrfy_done) begin
                    state_d  = RESP;
                    status_d = vrfy_error ? ST_ERR : (vrfy_valid ? ST_OK : ST_VFAIL);
                end else if (tmo_hit) begin
                    state_d  = RESP;
                    status_d = ST_TMO;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, status and captured job identity; reset discards any job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            status_q <= ST_OK;
            id_q     <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (accept) begin
                id_q  <= gnt_idx;
                tag_q <= gnt_tag;
            end
        end
    end

    assign hash_start = (state_q == H_START);
    assign sign_start = (state_q == S_START);
    assign vrfy_start = (state_q == V_START);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_tag    = tag_q;
    assign rsp_status = status_q;
    assign busy       = (state_q != IDLE);

endmodule
